// File: rtl/jls_axis_out_if.sv
// AXI4-Stream beat bundle used by the jls_axis_out adapter.
//   tvalid : beat valid              (master -> slave)
//   tready : sink ready              (slave  -> master)
//   tdata  : beat payload, 8*OUT_BYTES bits (master -> slave)
//   tlast  : final beat of a frame   (master -> slave)
interface jls_axis_out_if #(
   parameter int OUT_BYTES = 8
) ();
   logic                   tvalid;
   logic                   tready;
   logic [8*OUT_BYTES-1:0] tdata;
   logic                   tlast;

   modport master (output tvalid, output tdata, output tlast, input tready);
   modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/jls_axis_out.sv
// jls_axis_out: adapts the uh_jls encoder word stream (64-bit, no
// backpressure) to an AXI4-Stream master of OUT_BYTES-wide beats.
// Incoming words are buffered in a 2^DEPTH_LOG2-entry FIFO, then each word
// is serialised little-endian (byte 0 first) into 8/OUT_BYTES beats. The
// final beat of a frame carries tlast.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   i_e            input word valid (uh_jls o_e)
//   i_data         64-bit input word, byte 0 = [7:0]
//   i_last         input word ends a frame
//   m_axis         AXI4-Stream master (tvalid/tready/tdata/tlast)
//   o_level        FIFO word count, not counting the word being serialised
//   o_overflow     sticky: an input word was dropped because the FIFO was full
//   o_frame_cnt    frames fully emitted (tlast handshakes), wraps at 2^32
module jls_axis_out #(
   parameter int OUT_BYTES  = 8,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_e,
   input  logic [63:0]           i_data,
   input  logic                  i_last,
   jls_axis_out_if.master        m_axis,
   output logic [DEPTH_LOG2:0]   o_level,
   output logic                  o_overflow,
   output logic [31:0]           o_frame_cnt
);

   localparam int BW    = 8 * OUT_BYTES;
   localparam int BEATS = 8 / OUT_BYTES;
   localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;

   localparam logic [BI_W-1:0]       LAST_BI     = BI_W'(BEATS - 1);
   localparam logic [BI_W-1:0]       BI_ONE      = BI_W'(1);
   localparam logic [DEPTH_LOG2:0]   FULL_LVL    = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LVL_ONE     = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0]   LVL_ZERO    = (DEPTH_LOG2 + 1)'(0);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = DEPTH_LOG2'(1);
   localparam logic                  SINGLE_BEAT = (BEATS == 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   // FIFO storage and bookkeeping
   logic [64:0]           mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   level_r;
   logic                  overflow_r;
   logic [31:0]           frame_cnt_r;

   // serialiser
   state_t                state_r;
   logic [63:0]           word_r;
   logic                  last_r;
   logic [BI_W-1:0]       bi_r;
   logic                  tvalid_r;
   logic [BW-1:0]         tdata_r;
   logic                  tlast_r;

   logic                  full_s;
   logic                  empty_s;
   logic                  wr_s;
   logic                  hs_s;
   logic                  last_beat_s;
   logic                  pop_s;
   logic [64:0]           head_s;
   logic [BI_W-1:0]       bi_next_s;

   // Beat idx of a word, little-endian: beat 0 is the low BW bits.
   function automatic logic [BW-1:0] beat_of(input logic [63:0] w, input logic [BI_W-1:0] idx);
      logic [63:0] sh;
      sh = w >> (BW * int'(idx));
      return sh[BW-1:0];
   endfunction

   // FIFO status, handshake and the write/pop qualifiers.
   always_comb begin
      full_s      = (level_r == FULL_LVL);
      empty_s     = (level_r == LVL_ZERO);
      // full is judged on the registered level, so a same-cycle pop does not make room
      wr_s        = i_e & ~full_s;
      hs_s        = tvalid_r & m_axis.tready;
      last_beat_s = (bi_r == LAST_BI);
      bi_next_s   = bi_r + BI_ONE;
      head_s      = mem_r[rd_ptr_r];
      if (state_r == ST_IDLE) begin
         pop_s = ~empty_s;
      end else begin
         // refill on the last handshake of a word keeps the stream bubble-free
         pop_s = ~empty_s & hs_s & last_beat_s;
      end
   end

   // FIFO array write port (storage needs no reset).
   always_ff @(posedge clk) begin
      if (wr_s) begin
         mem_r[wr_ptr_r] <= {i_last, i_data};
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
         level_r    <= LVL_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (wr_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({wr_s, pop_s})
            2'b10:   level_r <= level_r + LVL_ONE;
            2'b01:   level_r <= level_r - LVL_ONE;
            default: level_r <= level_r;
         endcase
         if (i_e & full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Serialiser FSM: loads a word from the FIFO and walks its beats.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r  <= ST_IDLE;
         word_r   <= 64'd0;
         last_r   <= 1'b0;
         bi_r     <= {BI_W{1'b0}};
         tvalid_r <= 1'b0;
         tdata_r  <= {BW{1'b0}};
         tlast_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pop_s) begin
                  word_r   <= head_s[63:0];
                  last_r   <= head_s[64];
                  bi_r     <= {BI_W{1'b0}};
                  tvalid_r <= 1'b1;
                  tdata_r  <= head_s[BW-1:0];
                  tlast_r  <= head_s[64] & SINGLE_BEAT;
                  state_r  <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (hs_s) begin
                  if (!last_beat_s) begin
                     bi_r    <= bi_next_s;
                     tdata_r <= beat_of(word_r, bi_next_s);
                     tlast_r <= last_r & (bi_next_s == LAST_BI);
                  end else if (pop_s) begin
                     word_r  <= head_s[63:0];
                     last_r  <= head_s[64];
                     bi_r    <= {BI_W{1'b0}};
                     tdata_r <= head_s[BW-1:0];
                     tlast_r <= head_s[64] & SINGLE_BEAT;
                  end else begin
                     tvalid_r <= 1'b0;
                     tdata_r  <= {BW{1'b0}};
                     tlast_r  <= 1'b0;
                     state_r  <= ST_IDLE;
                  end
               end
            end
            default: begin
               tvalid_r <= 1'b0;
               tlast_r  <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   // Completed-frame counter, advanced on each tlast handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_cnt_r <= 32'd0;
      end else if (hs_s & tlast_r) begin
         frame_cnt_r <= frame_cnt_r + 32'd1;
      end else begin
         frame_cnt_r <= frame_cnt_r;
      end
   end

   assign m_axis.tvalid = tvalid_r;
   assign m_axis.tdata  = tdata_r;
   assign m_axis.tlast  = tlast_r;
   assign o_level       = level_r;
   assign o_overflow    = overflow_r;
   assign o_frame_cnt   = frame_cnt_r;

endmodule
